memory_arbiter: RTL and testbench

Shares the single main-memory port between the instruction cache (read-only line fills) and the data cache (line fills and write-backs). It arbitrates round-robin and holds one outstanding transaction at a time. It sequences the memory handshake and returns the line to the winning cache with a one-cycle ready pulse. It sits between both caches and the main-memory model inside the Abejaruco top level.

---
 rtl/memory_arbiter_pkg.sv | 18 +
 rtl/memory_arbiter_if.sv | 47 ++++
 rtl/memory_arbiter_rr_arbiter_2.sv | 20 ++
 rtl/memory_arbiter.sv | 111 +++++++++++
 tb/tb_memory_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/memory_arbiter_pkg.sv
// Shared types for the main-memory arbiter: FSM states, requester ids, default widths.
// Pure declarations, no timing and no backpressure.
package memory_arbiter_defs;
  localparam int DEFAULT_ADDRESS_WIDTH   = 32;
  localparam int DEFAULT_CACHE_LINE_SIZE = 128;
  localparam int DEFAULT_TIMEOUT_CYCLES  = 64;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_WAIT = 2'd1,
    RESPOND  = 2'd2
  } state_t;

  typedef enum logic {
    REQ_ICACHE = 1'b0,
    REQ_DCACHE = 1'b1
  } req_id_t;
endpackage

// File: rtl/memory_arbiter_if.sv
// Cache-side and memory-side handshake bundle; master is the arbiter, slave is caches plus memory.
// Requests are level-held until the matching one-cycle ready pulse; memory holds off via mem_ready.
interface memory_arbiter_if
  import memory_arbiter_defs::*;
#(
  parameter int ADDRESS_WIDTH   = DEFAULT_ADDRESS_WIDTH,
  parameter int CACHE_LINE_SIZE = DEFAULT_CACHE_LINE_SIZE
);
  logic                       icache_req;
  logic [ADDRESS_WIDTH-1:0]   icache_addr;
  logic                       icache_ready;
  logic [CACHE_LINE_SIZE-1:0] icache_rdata;
  logic                       icache_error;

  logic                       dcache_req;
  logic                       dcache_we;
  logic [ADDRESS_WIDTH-1:0]   dcache_addr;
  logic [CACHE_LINE_SIZE-1:0] dcache_wdata;
  logic                       dcache_ready;
  logic [CACHE_LINE_SIZE-1:0] dcache_rdata;
  logic                       dcache_error;

  logic                       mem_req;
  logic                       mem_we;
  logic [ADDRESS_WIDTH-1:0]   mem_addr;
  logic [CACHE_LINE_SIZE-1:0] mem_wdata;
  logic                       mem_ready;
  logic [CACHE_LINE_SIZE-1:0] mem_rdata;

  modport master (
    input  icache_req, icache_addr,
    input  dcache_req, dcache_we, dcache_addr, dcache_wdata,
    input  mem_ready, mem_rdata,
    output icache_ready, icache_rdata, icache_error,
    output dcache_ready, dcache_rdata, dcache_error,
    output mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output icache_req, icache_addr,
    output dcache_req, dcache_we, dcache_addr, dcache_wdata,
    output mem_ready, mem_rdata,
    input  icache_ready, icache_rdata, icache_error,
    input  dcache_ready, dcache_rdata, dcache_error,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/memory_arbiter_rr_arbiter_2.sv
// Two-input round-robin pick: a tie goes to whichever requester was not granted last.
// Purely combinational, zero latency; no backpressure of its own.
module rr_arbiter_2
  import memory_arbiter_defs::*;
(
  input  logic [1:0] req,
  input  req_id_t    last_grant,
  output req_id_t    grant,
  output logic       grant_valid
);
  always_comb begin
    grant_valid = |req;
    grant       = REQ_ICACHE;
    if (req == 2'b11) begin
      grant = (last_grant == REQ_ICACHE) ? REQ_DCACHE : REQ_ICACHE;
    end else if (req[1]) begin
      grant = REQ_DCACHE;
    end
  end
endmodule

// File: rtl/memory_arbiter.sv
// Shares the main-memory port between icache and dcache, round-robin, one transaction in flight.
// Ready pulses 2 cycles after grant with zero-wait memory; caches hold req until ready, memory stalls via mem_ready.
module memory_arbiter
  import memory_arbiter_defs::*;
#(
  parameter int ADDRESS_WIDTH   = DEFAULT_ADDRESS_WIDTH,
  parameter int CACHE_LINE_SIZE = DEFAULT_CACHE_LINE_SIZE,
  parameter int TIMEOUT_CYCLES  = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  memory_arbiter_if.master bus,
  output logic             busy
);
  localparam int               CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t                     state;
  req_id_t                    owner;
  req_id_t                    last_grant;
  req_id_t                    pick;
  logic                       pick_vld;
  logic [CNT_W-1:0]           wait_cnt;
  logic                       done;
  logic [CACHE_LINE_SIZE-1:0] fill_line;

  rr_arbiter_2 u_rr (
    .req         ({bus.dcache_req, bus.icache_req}),
    .last_grant  (last_grant),
    .grant       (pick),
    .grant_valid (pick_vld)
  );

  // A mem_ready on the last wait cycle still counts as success; write-backs hand back a zero line.
  always_comb begin
    done      = bus.mem_ready || (wait_cnt == LAST_CNT);
    fill_line = (bus.mem_ready && !bus.mem_we) ? bus.mem_rdata : {CACHE_LINE_SIZE{1'b0}};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      owner            <= REQ_ICACHE;
      last_grant       <= REQ_DCACHE;
      wait_cnt         <= '0;
      busy             <= 1'b0;
      bus.mem_req      <= 1'b0;
      bus.mem_we       <= 1'b0;
      bus.mem_addr     <= {ADDRESS_WIDTH{1'b0}};
      bus.mem_wdata    <= {CACHE_LINE_SIZE{1'b0}};
      bus.icache_ready <= 1'b0;
      bus.icache_error <= 1'b0;
      bus.icache_rdata <= {CACHE_LINE_SIZE{1'b0}};
      bus.dcache_ready <= 1'b0;
      bus.dcache_error <= 1'b0;
      bus.dcache_rdata <= {CACHE_LINE_SIZE{1'b0}};
    end else begin
      bus.icache_ready <= 1'b0;
      bus.icache_error <= 1'b0;
      bus.dcache_ready <= 1'b0;
      bus.dcache_error <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            state       <= MEM_WAIT;
            owner       <= pick;
            last_grant  <= pick;
            wait_cnt    <= '0;
            busy        <= 1'b1;
            bus.mem_req <= 1'b1;
            if (pick == REQ_ICACHE) begin
              bus.mem_we    <= 1'b0;
              bus.mem_addr  <= bus.icache_addr;
              bus.mem_wdata <= {CACHE_LINE_SIZE{1'b0}};
            end else begin
              bus.mem_we    <= bus.dcache_we;
              bus.mem_addr  <= bus.dcache_addr;
              bus.mem_wdata <= bus.dcache_wdata;
            end
          end
        end
        MEM_WAIT: begin
          if (done) begin
            state       <= RESPOND;
            bus.mem_req <= 1'b0;
            if (owner == REQ_ICACHE) begin
              bus.icache_ready <= 1'b1;
              bus.icache_error <= !bus.mem_ready;
              bus.icache_rdata <= fill_line;
            end else begin
              bus.dcache_ready <= 1'b1;
              bus.dcache_error <= !bus.mem_ready;
              bus.dcache_rdata <= fill_line;
            end
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        RESPOND: begin
          state    <= IDLE;
          busy     <= 1'b0;
          wait_cnt <= '0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: transaction-timeline model checked every cycle plus literal checks per scenario.
module tb_memory_arbiter;
  import memory_arbiter_defs::*;

  localparam int TO = 64;

  typedef struct {
    int           owner;
    logic         err;
    logic [127:0] rdata;
    int           cyc;
  } pulse_t;

  logic clk;
  logic reset;
  logic busy;

  memory_arbiter_if #(.ADDRESS_WIDTH(32), .CACHE_LINE_SIZE(128)) bus ();

  memory_arbiter #(
    .ADDRESS_WIDTH   (32),
    .CACHE_LINE_SIZE (128),
    .TIMEOUT_CYCLES  (TO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy)
  );

  logic [1:0] rr_req;
  req_id_t    rr_last;
  req_id_t    rr_grant;
  logic       rr_vld;

  rr_arbiter_2 u_rr (
    .req         (rr_req),
    .last_grant  (rr_last),
    .grant       (rr_grant),
    .grant_valid (rr_vld)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // stimulus knobs, applied by the driver one cycle at a time
  int           i_todo   = 0;
  int           d_todo   = 0;
  int           mem_wait = 0;
  logic [31:0]  i_addr   = 0;
  logic [31:0]  d_addr   = 0;
  logic         d_we     = 0;
  logic [127:0] d_wdata  = 0;

  pulse_t      pq[$];
  int          ms_q[$];
  int          ml_q[$];
  logic [31:0] ma_q[$];
  logic        mw_q[$];

  // model state
  bit           m_active = 0;
  int           m_g = 0, m_w = 0, m_owner = 0, m_last = 1;
  bit           m_err = 0, m_we = 0;
  logic [31:0]  m_addr = 0;
  logic [127:0] m_wdata = 0, m_line = 0, m_irdata = 0, m_drdata = 0;

  function automatic logic [127:0] line_of(input logic [31:0] a);
    return {a + 32'd4, a + 32'd3, a + 32'd2, a + 32'd1};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // Cache requesters and memory responder
  initial begin : driver
    int   k;
    logic i_seen, d_seen;
    k = 0;
    bus.icache_req   = 1'b0;
    bus.icache_addr  = '0;
    bus.dcache_req   = 1'b0;
    bus.dcache_we    = 1'b0;
    bus.dcache_addr  = '0;
    bus.dcache_wdata = '0;
    bus.mem_ready    = 1'b0;
    bus.mem_rdata    = '0;
    forever begin
      @(negedge clk);
      i_seen = bus.icache_ready;
      d_seen = bus.dcache_ready;
      @(posedge clk);
      #1;
      if (i_seen && i_todo > 0) i_todo--;
      if (d_seen && d_todo > 0) d_todo--;
      bus.icache_req   = (i_todo > 0);
      bus.icache_addr  = i_addr;
      bus.dcache_req   = (d_todo > 0);
      bus.dcache_we    = d_we;
      bus.dcache_addr  = d_addr;
      bus.dcache_wdata = d_wdata;
      if (bus.mem_req) begin
        bus.mem_ready = (mem_wait >= 0) && (k == mem_wait);
        bus.mem_rdata = line_of(bus.mem_addr);
        k++;
      end else begin
        k             = 0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
      end
    end
  end

  // Model: each grant fixes a timeline g..g+w (mem_req) and ready at g+w+1
  initial begin : compare
    int   r, run;
    bit   in_txn, e_req, at_r, prev_mreq;
    run       = 0;
    prev_mreq = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        m_active = 0;
        m_last   = 1;
        m_irdata = '0;
        m_drdata = '0;
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        chk("rst_icache_ready", bus.icache_ready, 0);
        chk("rst_icache_error", bus.icache_error, 0);
        chk("rst_icache_rdata", bus.icache_rdata, 0);
        chk("rst_dcache_ready", bus.dcache_ready, 0);
        chk("rst_dcache_error", bus.dcache_error, 0);
        chk("rst_dcache_rdata", bus.dcache_rdata, 0);
        chk("rst_busy", busy, 0);
      end else begin
        r      = m_g + m_w + 1;
        in_txn = m_active && (cyc >= m_g) && (cyc <= r);
        at_r   = m_active && (cyc == r);
        e_req  = in_txn && (cyc < r);
        if (at_r) begin
          if (m_owner == 0) m_irdata = m_line;
          else              m_drdata = m_line;
        end
        chk("busy", busy, in_txn);
        chk("mem_req", bus.mem_req, e_req);
        if (e_req) begin
          chk("mem_addr", bus.mem_addr, m_addr);
          chk("mem_we", bus.mem_we, m_we);
          chk("mem_wdata", bus.mem_wdata, m_wdata);
        end
        chk("icache_ready", bus.icache_ready, at_r && m_owner == 0);
        chk("icache_error", bus.icache_error, at_r && m_owner == 0 && m_err);
        chk("dcache_ready", bus.dcache_ready, at_r && m_owner == 1);
        chk("dcache_error", bus.dcache_error, at_r && m_owner == 1 && m_err);
        chk("icache_rdata", bus.icache_rdata, m_irdata);
        chk("dcache_rdata", bus.dcache_rdata, m_drdata);
        if (at_r) begin
          m_active = 0;
        end else if (!m_active && (bus.icache_req || bus.dcache_req)) begin
          if (bus.icache_req && bus.dcache_req) m_owner = (m_last == 1) ? 0 : 1;
          else                                  m_owner = bus.dcache_req ? 1 : 0;
          m_last   = m_owner;
          m_active = 1;
          m_g      = cyc + 1;
          m_err    = (mem_wait < 0) || (mem_wait > TO - 1);
          m_w      = m_err ? TO - 1 : mem_wait;
          m_addr   = (m_owner == 0) ? bus.icache_addr : bus.dcache_addr;
          m_we     = (m_owner == 1) && bus.dcache_we;
          m_wdata  = (m_owner == 0) ? 128'd0 : bus.dcache_wdata;
          m_line   = (m_err || m_we) ? 128'd0 : line_of(m_addr);
        end
      end
      if (bus.icache_ready || bus.dcache_ready) begin
        pulse_t p;
        p.owner = (bus.icache_ready && bus.dcache_ready) ? 2 : (bus.icache_ready ? 0 : 1);
        p.err   = bus.icache_ready ? bus.icache_error : bus.dcache_error;
        p.rdata = bus.icache_ready ? bus.icache_rdata : bus.dcache_rdata;
        p.cyc   = cyc;
        pq.push_back(p);
      end
      if (bus.mem_req && !prev_mreq) begin
        ms_q.push_back(cyc);
        ma_q.push_back(bus.mem_addr);
        mw_q.push_back(bus.mem_we);
        run = 0;
      end
      if (bus.mem_req) run++;
      if (!bus.mem_req && prev_mreq) ml_q.push_back(run);
      prev_mreq = bus.mem_req;
    end
  end

  task automatic wait_pulses(input int target, input int budget, input string name);
    int c;
    c = 0;
    while (pq.size() < target && c < budget) begin
      @(negedge clk);
      #1;
      c++;
    end
    if (pq.size() < target) chk(name, pq.size(), target);
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
    #1;
  endtask

  initial begin : stim
    int base, e, c;
    reset = 1'b0;

    for (int k = 0; k < 8; k++) begin
      rr_req  = k[1:0];
      rr_last = k[2] ? REQ_DCACHE : REQ_ICACHE;
      #1;
      chk("rr_valid", rr_vld, k[1:0] != 2'b00);
      if (k[1:0] == 2'b11) e = k[2] ? 0 : 1;
      else                 e = k[1] ? 1 : 0;
      if (k[1:0] != 2'b00) chk("rr_grant", rr_grant, e);
    end

    // reset, then a zero-wait icache fill
    i_addr   = 32'h0;
    i_todo   = 1;
    mem_wait = 0;
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    wait_pulses(1, 20, "p1_wait");
    if (pq.size() >= 1 && ms_q.size() >= 1) begin
      chk("p1_owner", pq[0].owner, 0);
      chk("p1_error", pq[0].err, 0);
      chk("p1_rdata", pq[0].rdata, 128'h00000004_00000003_00000002_00000001);
      chk("p1_latency", pq[0].cyc - (ms_q[0] - 1), 2);
      chk("p1_mem_addr", ma_q[0], 32'h0);
    end
    settle();

    // dcache write-back with 3 wait cycles
    base     = pq.size();
    d_addr   = 32'h80;
    d_we     = 1'b1;
    d_wdata  = 128'hDEADBEEF_00000000_00000000_CAFEF00D;
    mem_wait = 3;
    d_todo   = 1;
    wait_pulses(base + 1, 30, "wb_wait");
    if (pq.size() > base) begin
      chk("wb_owner", pq[base].owner, 1);
      chk("wb_rdata", pq[base].rdata, 128'h0);
      chk("wb_error", pq[base].err, 0);
      chk("wb_mem_req_len", ml_q[$], 4);
      chk("wb_mem_we", mw_q[$], 1);
    end
    settle();

    // tie: last grant was dcache, so icache, dcache, icache
    base     = pq.size();
    d_we     = 1'b0;
    d_addr   = 32'h40;
    d_wdata  = 128'h0;
    i_addr   = 32'h0;
    mem_wait = 0;
    i_todo   = 2;
    d_todo   = 1;
    wait_pulses(base + 3, 40, "tie_wait");
    if (pq.size() >= base + 3 && ma_q.size() >= 3) begin
      chk("tie_owner0", pq[base].owner, 0);
      chk("tie_owner1", pq[base + 1].owner, 1);
      chk("tie_owner2", pq[base + 2].owner, 0);
      chk("tie_rdata1", pq[base + 1].rdata, 128'h00000044_00000043_00000042_00000041);
      chk("tie_addr0", ma_q[ma_q.size() - 3], 32'h0);
      chk("tie_addr1", ma_q[ma_q.size() - 2], 32'h40);
      chk("tie_addr2", ma_q[ma_q.size() - 1], 32'h0);
    end
    settle();

    // memory never answers
    base     = pq.size();
    mem_wait = -1;
    i_addr   = 32'h100;
    i_todo   = 1;
    wait_pulses(base + 1, 100, "to_wait");
    if (pq.size() > base) begin
      chk("to_owner", pq[base].owner, 0);
      chk("to_error", pq[base].err, 1);
      chk("to_rdata", pq[base].rdata, 128'h0);
      chk("to_mem_req_len", ml_q[$], 64);
      @(negedge clk);
      #1;
      chk("to_busy_after", busy, 0);
    end
    settle();

    // reset while waiting on memory
    mem_wait = 10;
    i_addr   = 32'h200;
    i_todo   = 1;
    c = 0;
    while (!bus.mem_req && c < 20) begin
      @(negedge clk);
      #1;
      c++;
    end
    if (!bus.mem_req) chk("midrst_wait_req", bus.mem_req, 1);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("midrst_mem_req", bus.mem_req, 0);
    chk("midrst_busy", busy, 0);
    base = pq.size();
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    chk("midrst_no_pulse", pq.size(), base);
    wait_pulses(base + 1, 40, "midrst_regrant");
    if (pq.size() > base) begin
      chk("midrst_owner", pq[base].owner, 0);
      chk("midrst_error", pq[base].err, 0);
      chk("midrst_rdata", pq[base].rdata, 128'h00000204_00000203_00000202_00000201);
    end
    settle();

    // mem_ready lands on the final timeout cycle
    base     = pq.size();
    mem_wait = 63;
    i_addr   = 32'h300;
    i_todo   = 1;
    wait_pulses(base + 1, 100, "edge_wait");
    if (pq.size() > base) begin
      chk("edge_error", pq[base].err, 0);
      chk("edge_rdata", pq[base].rdata, 128'h00000304_00000303_00000302_00000301);
      chk("edge_mem_req_len", ml_q[$], 64);
    end
    settle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
